// File: rtl/i2s_tx_pkg.sv
// Shared constants for the synthesizer audio path and the I2S transmitter.
// The helper picks the serial bit for a given slot of a left-justified frame.
package i2s_tx_pkg;

  localparam int SYNTH_WIDTH      = 16;
  localparam int I2S_BITS         = 24;
  localparam int I2S_SLOT_BITS    = 32;
  localparam int I2S_FRAME_CYCLES = 2048;

  localparam int CNT_W  = $clog2(I2S_FRAME_CYCLES);
  localparam int SLOT_W = $clog2(I2S_SLOT_BITS);

  // Slot 0 is the one-SCLK I2S delay; slots 1..24 carry MSB..LSB; the rest pad with zero.
  function automatic logic slot_bit(input logic [I2S_BITS-1:0] frame,
                                    input logic [SLOT_W-1:0]   slot);
    logic [SLOT_W-1:0] idx;
    idx = SLOT_W'(I2S_BITS) - slot;
    if (slot >= SLOT_W'(1) && slot <= SLOT_W'(I2S_BITS)) begin
      return frame[idx];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: one-deep hold buffer feeding a 24-bit frame register,
// with MCLK/SCLK/LRCK all derived from a single free-running frame counter.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int WIDTH = SYNTH_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    mclk_out,
  output logic                    sclk_out,
  output logic                    lrck_out,
  output logic                    sdin_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);

  logic [CNT_W-1:0]    cnt;
  logic                hold_full;
  logic [I2S_BITS-1:0] hold_q;
  logic [I2S_BITS-1:0] frame_q;
  logic                sdin_q;

  logic                frame_end;
  logic                accept;
  logic                slot_end;
  logic [SLOT_W-1:0]   next_slot;
  logic [I2S_BITS-1:0] sample_lj;

  // Handshake: a sample transfers on any rising clk_in edge where
  // sample_valid_in and sample_ready_out are both high; ready is simply !hold_full.
  assign frame_end = (cnt == CNT_W'(I2S_FRAME_CYCLES - 1));
  assign accept    = sample_valid_in && !hold_full;
  assign slot_end  = &cnt[SLOT_W-1:0];
  assign next_slot = cnt[CNT_W-2:CNT_W-1-SLOT_W] + SLOT_W'(1);
  assign sample_lj = I2S_BITS'($unsigned(sample_in)) << (I2S_BITS - WIDTH);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt       <= '0;
      hold_full <= 1'b0;
      hold_q    <= '0;
      frame_q   <= '0;
      sdin_q    <= 1'b0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      // Load and accept are exclusive: accept needs an empty hold, load needs a full one.
      if (frame_end && hold_full) begin
        frame_q   <= hold_q;
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_q    <= sample_lj;
        hold_full <= 1'b1;
      end
      // Present the next slot's bit as SCLK falls so the DAC samples it mid-slot.
      if (slot_end) begin
        sdin_q <= slot_bit(frame_q, next_slot);
      end
    end
  end

  assign sample_ready_out = !hold_full;
  assign mclk_out         = cnt[2];
  assign sclk_out         = cnt[4];
  assign lrck_out         = cnt[CNT_W-1];
  assign sdin_out         = sdin_q;
  assign frame_start_out  = frame_end;
  assign underrun_out     = frame_end && !hold_full;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx at WIDTH=16: table-driven samples through a scoreboard,
// plus reset, backpressure, underrun, edge-acceptance and mid-frame reset sequences.
module tb_i2s_tx;
  import i2s_tx_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] sample;
    logic [23:0]  frame;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [W-1:0] sample_in = '0;
  logic                sample_valid_in = 1'b0;
  logic                sample_ready_out;
  logic                mclk_out, sclk_out, lrck_out, sdin_out;
  logic                frame_start_out, underrun_out;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [10:0] tb_cnt;
  logic [23:0] exp_q[$];
  logic [23:0] cur_frame = '0;

  i2s_tx #(.WIDTH(W)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .sample_ready_out(sample_ready_out),
    .mclk_out        (mclk_out),
    .sclk_out        (sclk_out),
    .lrck_out        (lrck_out),
    .sdin_out        (sdin_out),
    .frame_start_out (frame_start_out),
    .underrun_out    (underrun_out)
  );

  // clock / reset-tracking block
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 11'd1;
  end

  always @(negedge rst_n) begin
    exp_q.delete();
    cur_frame = '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cnt=%0d)", name, act, exp, tb_cnt);
    end
  endtask

  // scoreboard monitor: frame loads pop the expected queue, slots are checked mid-bit
  always @(negedge clk) begin
    int  b;
    logic exp_bit;
    if (rst_n) begin
      if (tb_cnt == 11'd2047) begin
        check("frame_start", frame_start_out, 1);
        if (exp_q.size() > 0) begin
          check("underrun_load", underrun_out, 0);
          cur_frame = exp_q.pop_front();
        end else begin
          check("underrun_empty", underrun_out, 1);
        end
      end else if (tb_cnt == 11'd0 || tb_cnt == 11'd2046) begin
        check("frame_start_idle", frame_start_out, 0);
        check("underrun_idle", underrun_out, 0);
      end
      if (tb_cnt[4:0] == 5'd16) begin
        b = int'(tb_cnt[9:5]);
        exp_bit = (b >= 1 && b <= 24) ? cur_frame[24-b] : 1'b0;
        check($sformatf("sdin_lr%0d_b%0d", tb_cnt[10], b), sdin_out, exp_bit);
        check("ready", sample_ready_out, exp_q.size() == 0);
      end
    end
  end

  // driver tasks (entered and left on a falling clock edge)
  task automatic send(input logic [W-1:0] s, input logic [23:0] exp, output int acc_cnt);
    bit done = 0;
    acc_cnt = -1;
    sample_in = s;
    sample_valid_in = 1'b1;
    for (int k = 0; k < 5000 && !done; k++) begin
      if (sample_ready_out) begin
        acc_cnt = int'(tb_cnt);
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        sample_valid_in = 1'b0;
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      sample_valid_in = 1'b0;
      check("send_timeout", 1, 0);
    end
  endtask

  task automatic wait_cnt(input int target);
    bit hit = 0;
    for (int k = 0; k < 5000 && !hit; k++) begin
      @(negedge clk);
      if (int'(tb_cnt) == target) hit = 1;
    end
    if (!hit) check("wait_timeout", 1, 0);
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return mclk_out;
      1:       return sclk_out;
      default: return lrck_out;
    endcase
  endfunction

  task automatic measure(input int sel, output int period);
    int   t0 = -1;
    logic prev, cur;
    period = -1;
    prev = pick(sel);
    for (int k = 0; k < 5000 && period < 0; k++) begin
      @(negedge clk);
      cur = pick(sel);
      if (cur && !prev) begin
        if (t0 < 0) t0 = cyc;
        else        period = cyc - t0;
      end
      prev = cur;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mclk"},   mclk_out, 0);
    check({tag, "_sclk"},   sclk_out, 0);
    check({tag, "_lrck"},   lrck_out, 0);
    check({tag, "_sdin"},   sdin_out, 0);
    check({tag, "_fstart"}, frame_start_out, 0);
    check({tag, "_under"},  underrun_out, 0);
    check({tag, "_ready"},  sample_ready_out, 1);
  endtask

  initial begin
    vec_t vecs[5];
    int   acc, acc2, per;
    logic [W-1:0] r;

    vecs[0] = '{sample: 16'h8001, frame: 24'h800100};
    vecs[1] = '{sample: 16'h7FFF, frame: 24'h7FFF00};
    vecs[2] = '{sample: 16'h0001, frame: 24'h000100};
    vecs[3] = '{sample: 16'hFFFF, frame: 24'hFFFF00};
    vecs[4] = '{sample: 16'h5A5A, frame: 24'h5A5A00};

    // reset held for 10 cycles
    repeat (10) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    measure(0, per); check("mclk_period", per, 8);
    measure(1, per); check("sclk_period", per, 32);
    measure(2, per); check("lrck_period", per, 2048);

    // table-driven samples, including 0x8001 -> 0x800100
    wait_cnt(100);
    for (int i = 0; i < 5; i++) send(vecs[i].sample, vecs[i].frame, acc);

    for (int i = 0; i < 3; i++) begin
      r = W'($urandom_range(0, 65535));
      send(r, {r, 8'h00}, acc);
    end

    // backpressure: second sample waits for the frame load
    wait_cnt(2047);
    wait_cnt(100);
    send(16'h1234, 24'h123400, acc);
    check("bp_first_acc", acc, 100);
    check("bp_ready_drop", sample_ready_out, 0);
    send(16'hC3C3, 24'hC3C300, acc2);
    check("bp_second_acc", acc2, 0);

    // underrun: 0xC3C3 loads, then a frame passes with nothing new
    wait_cnt(2047);
    wait_cnt(2047);
    check("underrun_pulse", underrun_out, 1);
    wait_cnt(1800);

    // edge acceptance at cnt==2047 with hold empty
    wait_cnt(2047);
    check("edge_underrun", underrun_out, 1);
    send(16'h0F0F, 24'h0F0F00, acc);
    check("edge_acc_cnt", acc, 2047);
    wait_cnt(2047);
    check("edge_load_no_under", underrun_out, 0);
    wait_cnt(1800);

    // reset mid-frame with 0x7FFF held
    wait_cnt(100);
    send(16'h7FFF, 24'h7FFF00, acc);
    wait_cnt(700);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(2047);
    check("post_reset_underrun", underrun_out, 1);
    wait_cnt(1800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
